// File: rtl/matmul_pkg.sv
// Shared types and sizing for the systolic matmul operand sequencer.
package matmul_pkg;

  localparam int BITS_AB        = 8;
  localparam int DIM            = 8;
  localparam int COMPUTE_CYCLES = 3 * DIM - 2;
  localparam int ROW_W          = $clog2(DIM);
  localparam int CYC_W          = $clog2(COMPUTE_CYCLES);

  typedef logic signed [BITS_AB-1:0] row_t [DIM-1:0];

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    LOAD_A,
    COMPUTE,
    CLEAR,
    DONE
  } seq_state_t;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Row-stream handshake between an upstream operand source and the sequencer.
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
();

  logic row_valid;
  logic row_ready;
  row_t row_data;

  modport master (output row_valid, output row_data, input row_ready);
  modport slave  (input row_valid, input row_data, output row_ready);

endinterface

// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for the matmul operand buffers: shift B in, write A by row,
// hold enable for one systolic sweep, zero-clear A, then pulse done.
module matmul_seq_ctrl
  import matmul_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  matmul_seq_ctrl_if.slave         row_if,
  output logic                     mem_en,
  output row_t                     b_in,
  output logic                     a_wr_en,
  output logic [ROW_W-1:0]         a_row,
  output row_t                     a_in,
  output logic                     busy,
  output logic                     done
);

  seq_state_t       state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;

  logic row_last;
  logic cyc_last;

  assign row_last = (row_cnt_q == ROW_W'(DIM - 1));
  assign cyc_last = (cyc_cnt_q == CYC_W'(COMPUTE_CYCLES - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d          = state_q;
    row_cnt_d        = row_cnt_q;
    cyc_cnt_d        = cyc_cnt_q;
    row_if.row_ready = 1'b0;
    mem_en           = 1'b0;
    b_in             = '{default: '0};
    a_wr_en          = 1'b0;
    a_row            = '0;
    a_in             = '{default: '0};
    done             = 1'b0;
    busy             = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_B;
          row_cnt_d = '0;
        end
      end

      LOAD_B: begin
        row_if.row_ready = 1'b1;
        b_in             = row_if.row_data;
        // memB shifts only on accepted rows, so bubbles stall in place
        mem_en           = row_if.row_valid;
        if (row_if.row_valid) begin
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = LOAD_A;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end

      LOAD_A: begin
        row_if.row_ready = 1'b1;
        a_wr_en          = row_if.row_valid;
        a_row            = row_cnt_q;
        a_in             = row_if.row_data;
        if (row_if.row_valid) begin
          if (row_last) begin
            row_cnt_d = '0;
            cyc_cnt_d = '0;
            state_d   = COMPUTE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end

      COMPUTE: begin
        mem_en = 1'b1;
        if (cyc_last) begin
          cyc_cnt_d = '0;
          row_cnt_d = '0;
          state_d   = CLEAR;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      CLEAR: begin
        a_wr_en = 1'b1;
        a_row   = row_cnt_q;
        if (row_last) begin
          row_cnt_d = '0;
          state_d   = DONE;
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides any transition; outputs this cycle still follow state_q.
    if (abort) begin
      state_d   = IDLE;
      row_cnt_d = '0;
      cyc_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed self-checking bench for matmul_seq_ctrl: reset, full jobs with and
// without bubbles, abort in compute, start while busy, back-to-back jobs.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  localparam int RW      = DIM * BITS_AB;
  localparam int LATENCY = 2 * DIM + COMPUTE_CYCLES + DIM + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             mem_en;
  row_t             b_in;
  logic             a_wr_en;
  logic [ROW_W-1:0] a_row;
  row_t             a_in;
  logic             busy;
  logic             done;

  matmul_seq_ctrl_if row_if ();

  matmul_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .row_if  (row_if),
    .mem_en  (mem_en),
    .b_in    (b_in),
    .a_wr_en (a_wr_en),
    .a_row   (a_row),
    .a_in    (a_in),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  row_t mat_a [DIM];
  row_t mat_b [DIM];
  row_t junk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input row_t r);
    logic [RW-1:0] p;
    p = '0;
    for (int i = 0; i < DIM; i++) p[i*BITS_AB +: BITS_AB] = r[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_matrices();
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = BITS_AB'($random);
        mat_b[r][c] = BITS_AB'($random);
        junk[c]     = BITS_AB'($random);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   busy,             '0);
    check({tag, "_done"},   done,             '0);
    check({tag, "_ready"},  row_if.row_ready, '0);
    check({tag, "_mem_en"}, mem_en,           '0);
    check({tag, "_a_wr"},   a_wr_en,          '0);
    check({tag, "_a_row"},  a_row,            '0);
    check({tag, "_a_in"},   pack(a_in),       '0);
    check({tag, "_b_in"},   pack(b_in),       '0);
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle
  // after done (or after the abort has taken effect).
  task automatic run_job(input bit bubbles, input int abort_at, input bit poke_start);
    int  cyc;
    int  nbub;
    int  nb;
    int  na;
    int  r;
    int  t;
    bit  v;

    cyc  = 0;
    nbub = 0;
    nb   = 0;
    na   = 0;
    start = 1'b1;
    @(negedge clk);
    check("pre_start_busy", busy, '0);
    tick();
    start = 1'b0;
    cyc   = 1;

    r = 0;
    t = 0;
    while (r < DIM) begin
      v = bubbles ? (t % 2 == 0) : 1'b1;
      row_if.row_valid = v;
      row_if.row_data  = v ? mat_b[r] : junk;
      @(negedge clk);
      check("b_ready", row_if.row_ready, 1);
      check("b_busy",  busy,             1);
      check("b_mem_en", mem_en,          RW'(v));
      check("b_a_wr",  a_wr_en,          '0);
      if (v) begin
        check($sformatf("b_in_row%0d", r), pack(b_in), pack(mat_b[r]));
        nb++;
        r++;
      end else begin
        nbub++;
      end
      tick();
      t++;
      cyc++;
    end

    r = 0;
    t = 0;
    while (r < DIM) begin
      v = bubbles ? (t % 2 == 0) : 1'b1;
      row_if.row_valid = v;
      row_if.row_data  = v ? mat_a[r] : junk;
      start = (poke_start && r == 3);
      @(negedge clk);
      check("a_ready",  row_if.row_ready, 1);
      check("a_mem_en", mem_en,           '0);
      check("a_b_in",   pack(b_in),       '0);
      check("a_wr",     a_wr_en,          RW'(v));
      if (v) begin
        check($sformatf("a_row%0d", r), a_row,      RW'(r));
        check($sformatf("a_in%0d", r),  pack(a_in), pack(mat_a[r]));
        na++;
        r++;
      end else begin
        nbub++;
      end
      tick();
      t++;
      cyc++;
    end
    start            = 1'b0;
    row_if.row_valid = 1'b0;
    row_if.row_data  = junk;
    check("b_shift_count", RW'(nb), RW'(DIM));
    check("a_write_count", RW'(na), RW'(DIM));

    for (int i = 0; i < COMPUTE_CYCLES; i++) begin
      @(negedge clk);
      check("c_mem_en", mem_en,           1);
      check("c_busy",   busy,             1);
      check("c_ready",  row_if.row_ready, '0);
      check("c_a_wr",   a_wr_en,          '0);
      check("c_b_in",   pack(b_in),       '0);
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_mem_en", mem_en, '0);
        check("abort_busy",   busy,   '0);
        check("abort_done",   done,   '0);
        tick();
        @(negedge clk);
        check("abort_stays_idle", busy, '0);
        check("abort_no_done",    done, '0);
        tick();
        return;
      end
      tick();
      cyc++;
    end

    for (int k = 0; k < DIM; k++) begin
      @(negedge clk);
      check("clr_a_wr",   a_wr_en,    1);
      check("clr_a_row",  a_row,      RW'(k));
      check("clr_a_in",   pack(a_in), '0);
      check("clr_mem_en", mem_en,     '0);
      check("clr_done",   done,       '0);
      tick();
      cyc++;
    end

    @(negedge clk);
    check("done_pulse",  done,   1);
    check("done_busy",   busy,   1);
    check("done_mem_en", mem_en, '0);
    check("done_a_wr",   a_wr_en, '0);
    check("latency",     RW'(cyc), RW'(LATENCY + nbub));
    if (bubbles) check("bubble_count", RW'(nbub), RW'(2 * (DIM - 1)));
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    start            = 1'b1;
    abort            = 1'b0;
    row_if.row_valid = 1'b0;
    for (int c = 0; c < DIM; c++) row_if.row_data[c] = '0;

    repeat (2) begin
      tick();
      @(negedge clk);
      check_idle("rst");
    end
    tick();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    tick();

    // start with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_idle("start_abort");
    tick();

    new_matrices();
    run_job(1'b0, -1, 1'b0);
    @(negedge clk);
    check_idle("after_job1");
    tick();

    new_matrices();
    run_job(1'b1, -1, 1'b0);

    new_matrices();
    run_job(1'b0, 5, 1'b0);
    new_matrices();
    run_job(1'b0, -1, 1'b0);

    new_matrices();
    run_job(1'b0, -1, 1'b1);
    @(negedge clk);
    check("single_done", done, '0);
    tick();

    // back-to-back: second job starts in the cycle right after done
    new_matrices();
    run_job(1'b0, -1, 1'b0);
    new_matrices();
    run_job(1'b0, -1, 1'b0);
    @(negedge clk);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
